// File: rtl/tpu_pkg.sv
// Shared types and constants for the activation requantize/pack path.
package tpu_pkg;
    localparam int ACT_W     = 32;
    localparam int Q_W       = 8;
    localparam int LANES     = 4;
    localparam int Q_MIN     = -128;
    localparam int Q_MAX     = 127;
    localparam int SCALE_W   = 16;
    localparam int PROD_W    = ACT_W + SCALE_W + 1;
    localparam int UB_ADDR_W = 8;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} pack_state_t;

    typedef struct packed {
        logic [UB_ADDR_W-1:0] addr;
        logic [ACT_W-1:0]     data;
        logic [LANES-1:0]     strb;
    } ub_wr_t;

    function automatic logic [Q_W-1:0] sat_q(input logic signed [PROD_W-1:0] r);
        if (r > PROD_W'(Q_MAX))
            return Q_W'(Q_MAX);
        else if (r < PROD_W'(Q_MIN))
            return Q_W'(Q_MIN);
        else
            return r[Q_W-1:0];
    endfunction
endpackage

// File: rtl/act_requant_packer_if.sv
// Unified-buffer word write port (valid/ready).
interface act_requant_packer_if #(parameter int ADDR_W = 8);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;

    modport master (output wr_valid, wr_addr, wr_data, wr_strb, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, wr_strb, output wr_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop frees a slot that same cycle.
module sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic empty,
    output logic full
);
    localparam int PW = $clog2(DEPTH);

    T             mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end
endmodule

// File: rtl/act_requant_packer.sv
// Requantizes the 32-bit activation stream to int8 and packs four bytes per unified-buffer word.
//   state  | meaning
//   IDLE   | waiting for start; samples arriving here are dropped
//   STREAM | accepting samples into the requant pipeline
//   DRAIN  | no new samples; finishing pipeline, partial word and FIFO
module act_requant_packer
    import tpu_pkg::*;
#(
    parameter int ADDR_W     = UB_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       flush,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [SCALE_W-1:0]         scale,
    input  logic [4:0]                 shift,
    input  logic                       valid_in,
    input  logic [ACT_W-1:0]           data_in,
    act_requant_packer_if.master       wr,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow
);
    pack_state_t              state, state_nxt;
    logic                     s1_valid, s2_valid;
    logic signed [PROD_W-1:0] s1_prod;
    logic signed [PROD_W-1:0] bias;
    logic signed [PROD_W-1:0] rounded;
    logic [Q_W-1:0]           s2_byte;
    logic [1:0]               lane;
    logic [23:0]              pack;
    logic [ADDR_W-1:0]        addr;
    logic                     push_valid;
    ub_wr_t                   push_entry;
    ub_wr_t                   head;
    logic                     fifo_empty, fifo_full, fifo_pop;
    logic                     take, pipe_empty, part_push, drain_ok, start_run;

    assign take       = valid_in && (state == STREAM);
    assign start_run  = (state == IDLE) && start;
    assign pipe_empty = !s1_valid && !s2_valid;
    assign part_push  = (state == DRAIN) && pipe_empty && (lane != 2'd0);
    assign drain_ok   = (state == DRAIN) && pipe_empty && (lane == 2'd0) && !push_valid && fifo_empty;
    assign fifo_pop   = wr.wr_valid && wr.wr_ready;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)    state_nxt = STREAM;
            STREAM:  if (flush)    state_nxt = DRAIN;
            DRAIN:   if (drain_ok) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Round half up toward +inf before the arithmetic shift.
    assign bias    = (shift == 5'd0) ? '0 : (PROD_W'(1) <<< (shift - 5'd1));
    assign rounded = (s1_prod + bias) >>> shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= drain_ok;
            if (start_run) overflow <= 1'b0;
            if ((valid_in && state != STREAM) || (push_valid && fifo_full && !fifo_pop))
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_prod    <= '0;
            s2_valid   <= 1'b0;
            s2_byte    <= '0;
            lane       <= '0;
            pack       <= '0;
            addr       <= '0;
            push_valid <= 1'b0;
            push_entry <= '0;
        end else begin
            s1_valid   <= take;
            s2_valid   <= s1_valid;
            push_valid <= 1'b0;
            if (take)     s1_prod <= $signed(data_in) * $signed({1'b0, scale});
            if (s1_valid) s2_byte <= sat_q(rounded);

            if (start_run) begin
                addr <= base_addr;
                lane <= '0;
                pack <= '0;
            end else if (s2_valid) begin
                if (lane == 2'd3) begin
                    push_valid      <= 1'b1;
                    push_entry.addr <= addr;
                    push_entry.data <= {s2_byte, pack};
                    push_entry.strb <= 4'hF;
                    addr            <= addr + ADDR_W'(1);
                    lane            <= '0;
                    pack            <= '0;
                end else begin
                    pack[8*lane +: 8] <= s2_byte;
                    lane              <= lane + 2'd1;
                end
            end else if (part_push) begin
                push_valid      <= 1'b1;
                push_entry.addr <= addr;
                push_entry.data <= {8'h00, pack};
                push_entry.strb <= 4'((4'd1 << lane) - 4'd1);
                addr            <= addr + ADDR_W'(1);
                lane            <= '0;
                pack            <= '0;
            end
        end
    end

    sync_fifo #(.T(ub_wr_t), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_valid),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign wr.wr_valid = !fifo_empty;
    assign wr.wr_addr  = fifo_empty ? '0 : head.addr;
    assign wr.wr_data  = fifo_empty ? '0 : head.data;
    assign wr.wr_strb  = fifo_empty ? '0 : head.strb;
endmodule

// File: tb/tb_act_requant_packer.sv
// Scoreboard bench for act_requant_packer: a byte/pack model queues expected writes as samples are driven.
`timescale 1ns/1ps
module tb_act_requant_packer;
    import tpu_pkg::*;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start, flush, valid_in;
    logic [7:0]  base_addr;
    logic [15:0] scale;
    logic [4:0]  shift;
    logic [31:0] data_in;
    logic        busy, done, overflow;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   exp_cap = 1000;
    bit   rand_ready = 0;

    logic [7:0]  m_addr;
    int          m_lane;
    logic [31:0] m_word;
    int          m_sc, m_sh;

    always #5 clk = ~clk;

    act_requant_packer_if #(.ADDR_W(8)) ub ();

    act_requant_packer #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .flush     (flush),
        .base_addr (base_addr),
        .scale     (scale),
        .shift     (shift),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .wr        (ub),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_q(int d, int sc, int sh);
        longint p;
        p = longint'(d) * longint'(sc);
        if (sh != 0) p = p + (longint'(1) << (sh - 1));
        p = p >>> sh;
        if (p > 127)  return 8'h7F;
        if (p < -128) return 8'h80;
        return p[7:0];
    endfunction

    function automatic void push_exp(logic [31:0] word, logic [3:0] strb);
        exp_t e;
        e.addr = m_addr;
        e.data = word;
        e.strb = strb;
        if (exp_q.size() < exp_cap) exp_q.push_back(e);
        m_addr = m_addr + 8'd1;
    endfunction

    function automatic void model_byte(logic [7:0] b);
        m_word[8*m_lane +: 8] = b;
        m_lane++;
        if (m_lane == 4) begin
            push_exp(m_word, 4'hF);
            m_word = '0;
            m_lane = 0;
        end
    endfunction

    function automatic void model_flush();
        logic [3:0] s;
        if (m_lane != 0) begin
            s = 4'((1 << m_lane) - 1);
            push_exp(m_word, s);
        end
        m_word = '0;
        m_lane = 0;
    endfunction

    // Every accepted write must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && ub.wr_valid && ub.wr_ready) begin
            chk("write_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(ub.wr_addr), 32'(mon_e.addr));
                chk("wr_data", ub.wr_data, mon_e.data);
                chk("wr_strb", 32'(ub.wr_strb), 32'(mon_e.strb));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            ub.wr_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(logic [7:0] base, logic [15:0] sc, logic [4:0] sh);
        base_addr = base;
        scale     = sc;
        shift     = sh;
        start     = 1'b1;
        tick();
        start  = 1'b0;
        m_addr = base;
        m_lane = 0;
        m_word = '0;
        m_sc   = int'(sc);
        m_sh   = int'(sh);
    endtask

    task automatic send(int v, bit with_flush = 0);
        valid_in = 1'b1;
        data_in  = v;
        flush    = with_flush;
        model_byte(ref_q(v, m_sc, m_sh));
        if (with_flush) model_flush();
        tick();
        valid_in = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        model_flush();
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_done(int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("done_pulse", 32'(seen), 1);
        tick();
        chk("done_one_cycle", 32'(done), 0);
        chk("idle_after_done", 32'(busy), 0);
        chk("all_writes_seen", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; valid_in = 1'b0;
        base_addr = '0; scale = '0; shift = '0; data_in = '0;
        ub.wr_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wr_valid", 32'(ub.wr_valid), 0);
        chk("rst_wr_data", ub.wr_data, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        tick();

        // identity scale, one full word, latency check
        ub.wr_ready = 1'b1;
        begin_run(8'h10, 16'd1, 5'd0);
        chk("busy_stream", 32'(busy), 1);
        send(1); send(2); send(3); send(4);
        repeat (3) @(negedge clk);
        chk("latency_edge2", 32'(ub.wr_valid), 0);
        @(negedge clk);
        chk("latency_edge3", 32'(ub.wr_valid), 1);
        tick();
        do_flush();
        wait_done(20);

        // rounding and saturation
        begin_run(8'h30, 16'd3, 5'd1);
        send(5); send(-5); send(1000); send(-1000);
        do_flush();
        wait_done(20);

        // partial word, flush alongside last sample, then empty flush
        begin_run(8'h50, 16'd1, 5'd0);
        send(7); send(8); send(9, 1);
        wait_done(20);
        begin_run(8'h60, 16'd1, 5'd0);
        do_flush();
        wait_done(20);
        chk("no_overflow_t3", 32'(overflow), 0);

        // write-side stall: four words queue, two dropped
        ub.wr_ready = 1'b0;
        begin_run(8'h40, 16'd1, 5'd0);
        exp_cap = 4;
        for (int i = 0; i < 24; i++) send(i + 1);
        repeat (6) tick();
        chk("stall_overflow", 32'(overflow), 1);
        chk("stall_wr_valid", 32'(ub.wr_valid), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_data", ub.wr_data, exp_q[0].data);
            chk("stall_addr", 32'(ub.wr_addr), 32'(exp_q[0].addr));
        end
        tick();
        ub.wr_ready = 1'b1;
        exp_cap = 1000;
        do_flush();
        wait_done(60);

        // address wrap
        begin_run(8'hFE, 16'd2, 5'd0);
        for (int i = 0; i < 12; i++) send(i * 3 - 10);
        do_flush();
        wait_done(30);

        // reset mid-run with words queued, then sample while idle
        ub.wr_ready = 1'b0;
        begin_run(8'h20, 16'd1, 5'd0);
        for (int i = 0; i < 8; i++) send(i);
        repeat (6) tick();
        chk("pre_reset_queued", 32'(ub.wr_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("post_reset_wr_valid", 32'(ub.wr_valid), 0);
        chk("post_reset_busy", 32'(busy), 0);
        chk("post_reset_overflow", 32'(overflow), 0);
        tick();
        ub.wr_ready = 1'b1;
        valid_in = 1'b1;
        data_in  = 32'd5;
        tick();
        valid_in = 1'b0;
        @(negedge clk);
        chk("idle_sample_overflow", 32'(overflow), 1);
        repeat (6) @(negedge clk);
        chk("idle_sample_no_write", 32'(ub.wr_valid), 0);
        tick();

        // random scale/shift/data with random write backpressure
        rand_ready = 1;
        for (int r = 0; r < 4; r++) begin
            int n;
            begin_run(8'($urandom_range(0, 255)), 16'($urandom), 5'($urandom_range(0, 31)));
            n = $urandom_range(1, 13);
            for (int i = 0; i < n; i++) send(int'($urandom));
            do_flush();
            wait_done(300);
        end
        rand_ready = 0;
        #2;
        ub.wr_ready = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
